// File: rtl/result_uart_tx.sv
// result_uart_tx: FIFO-buffered UART transmitter (start, 8 data bits LSB first, [even parity], stop)
//   clk       system clock, rising edge
//   RST_n     asynchronous active-low reset
//   trmt      one-cycle request to queue tx_data
//   tx_data   byte to queue, sampled when trmt=1
//   TX        serial line, idle high
//   tx_done   one-cycle pulse at the end of each stop bit
//   busy      frame on the line or FIFO non-empty
//   fifo_full FIFO holds FIFO_DEPTH bytes
//   overflow  sticky: a trmt was dropped
//   UART_TX_PARITY_EN (macro) adds an even-parity bit after data[7]
module result_uart_tx #(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       RST_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nxt;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [15:0] baud_cnt;
  logic [3:0] bit_cnt;
  logic [NB-1:0] sh, frame;
  logic pop, push, bit_end, last_bit;
  assign fifo_full = count == CW'(FIFO_DEPTH);
  assign pop = (state == IDLE) && (count != '0);
  assign push = trmt && (!fifo_full || pop);
  assign bit_end = baud_cnt == 16'(BAUD_DIV - 1);
  assign last_bit = bit_cnt == 4'(NB - 1);
  assign busy = (state == SHIFT) || (count != '0);
  assign TX = sh[0];
`ifdef UART_TX_PARITY_EN
  assign frame = {1'b1, ^mem[rd_ptr], mem[rd_ptr], 1'b0};
`else
  assign frame = {1'b1, mem[rd_ptr], 1'b0};
`endif
  always_comb state_nxt = pop ? SHIFT : (state == SHIFT && bit_end && last_bit) ? IDLE : state;
  always_ff @(posedge clk or negedge RST_n)
    if (!RST_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= tx_data;
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      tx_done  <= 1'b0;
      sh       <= '1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      tx_done <= 1'b0;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push != pop) count <= push ? count + CW'(1) : count - CW'(1);
      if (trmt && !push) overflow <= 1'b1;
      if (pop) begin
        sh       <= frame;
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end else if (state == SHIFT) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + 16'(1);
        if (bit_end) begin
          sh      <= {1'b1, sh[NB-1:1]};
          bit_cnt <= bit_cnt + 4'(1);
          tx_done <= last_bit;
        end
      end
    end
  end
endmodule
